// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Brief    : Valid/ready ALU. Logic, arithmetic, shift and compare ops finish
//            in one cycle. Multiply and divide ops run a WIDTH-step iterative
//            datapath (shift-add / restoring divide) on operand magnitudes.
// Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ALU_OP_i,
  input  logic [WIDTH-1:0] ALU_RS1_i,
  input  logic [WIDTH-1:0] ALU_RS2_i,
  input  logic             ALU_VALID_i,
  output logic             ALU_READY_o,
  output logic [WIDTH-1:0] ALU_RD_o,
  output logic             ALU_ZR_o,
  output logic             ALU_VALID_o,
  input  logic             ALU_READY_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_EQ     = 5'b00011;
  localparam logic [4:0] OP_SLL    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SRA    = 5'b00111;
  localparam logic [4:0] OP_XOR    = 5'b01000;
  localparam logic [4:0] OP_NOR    = 5'b01001;
  localparam logic [4:0] OP_SUB    = 5'b01010;
  localparam logic [4:0] OP_GE     = 5'b01100;
  localparam logic [4:0] OP_GEU    = 5'b01101;
  localparam logic [4:0] OP_SLT    = 5'b01110;
  localparam logic [4:0] OP_SLTU   = 5'b01111;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  localparam logic [SHW-1:0] CNT_LAST = {SHW{1'b1}};
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  state_t             state_q;
  logic [WIDTH-1:0]   rd_q;
  logic               zr_q;
  logic               valid_q;
  logic               ready_q;
  logic [SHW-1:0]     cnt_q;
  logic [4:0]         op_q;
  logic [2*WIDTH-1:0] p_q;     // {partial hi / remainder, multiplier / dividend}
  logic [WIDTH-1:0]   m_q;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_q;     // raw dividend, returned as remainder on /0
  logic               asgn_q;
  logic               bsgn_q;

  logic [WIDTH-1:0]   sc_res;
  logic [SHW-1:0]     shamt;
  logic               is_multi;
  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_tmp;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] p_d;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   mc_res;

  assign shamt    = ALU_RS2_i[SHW-1:0];
  assign is_multi = (ALU_OP_i[4:3] == 2'b10);

  // Single-cycle result straight from the request inputs
  always_comb begin
    sc_res = '0;
    case (ALU_OP_i)
      OP_AND:  sc_res = ALU_RS1_i & ALU_RS2_i;
      OP_OR:   sc_res = ALU_RS1_i | ALU_RS2_i;
      OP_ADD:  sc_res = ALU_RS1_i + ALU_RS2_i;
      OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (ALU_RS1_i == ALU_RS2_i)};
      OP_SLL:  sc_res = ALU_RS1_i << shamt;
      OP_SRL:  sc_res = ALU_RS1_i >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(ALU_RS1_i) >>> shamt);
      OP_XOR:  sc_res = ALU_RS1_i ^ ALU_RS2_i;
      OP_NOR:  sc_res = ~(ALU_RS1_i | ALU_RS2_i);
      OP_SUB:  sc_res = ALU_RS1_i - ALU_RS2_i;
      OP_GE:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(ALU_RS1_i) >= $signed(ALU_RS2_i))};
      OP_GEU:  sc_res = {{(WIDTH-1){1'b0}}, (ALU_RS1_i >= ALU_RS2_i)};
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(ALU_RS1_i) < $signed(ALU_RS2_i))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (ALU_RS1_i < ALU_RS2_i)};
      default: sc_res = '0;
    endcase
  end

  // Operand signs and magnitudes; the iterative datapath works unsigned
  always_comb begin
    a_sgn = ((ALU_OP_i == OP_MULH) || (ALU_OP_i == OP_MULHSU) ||
             (ALU_OP_i == OP_DIV)  || (ALU_OP_i == OP_REM)) && ALU_RS1_i[WIDTH-1];
    b_sgn = ((ALU_OP_i == OP_MULH) || (ALU_OP_i == OP_DIV) ||
             (ALU_OP_i == OP_REM)) && ALU_RS2_i[WIDTH-1];
    a_mag = a_sgn ? -ALU_RS1_i : ALU_RS1_i;
    b_mag = b_sgn ? -ALU_RS2_i : ALU_RS2_i;
  end

  // One shift-add or one restoring-divide step, plus final sign fix-up
  always_comb begin
    mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
    mul_step = p_q[0] ? {mul_sum, p_q[WIDTH-1:1]}
                      : {1'b0, p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1:1]};
    div_tmp  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_ge   = (div_tmp >= {1'b0, m_q});
    // A successful subtract always leaves a value below the divisor, so it fits in WIDTH bits
    div_rem  = div_ge ? (div_tmp[WIDTH-1:0] - m_q) : div_tmp[WIDTH-1:0];
    div_step = {div_rem, p_q[WIDTH-2:0], div_ge};
    p_d      = op_q[2] ? div_step : mul_step;
    prod     = (asgn_q ^ bsgn_q) ? -p_d : p_d;
    quo      = p_d[WIDTH-1:0];
    rem      = p_d[2*WIDTH-1:WIDTH];
    mc_res   = '0;
    case (op_q)
      OP_MUL:                       mc_res = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: mc_res = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:
        mc_res = (m_q == '0) ? {WIDTH{1'b1}} : ((asgn_q ^ bsgn_q) ? -quo : quo);
      OP_REM, OP_REMU:
        mc_res = (m_q == '0) ? a_q : (asgn_q ? -rem : rem);
      default: mc_res = '0;
    endcase
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= '0;
      zr_q    <= 1'b1;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
      op_q    <= '0;
      p_q     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      asgn_q  <= 1'b0;
      bsgn_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ALU_VALID_i) begin
            op_q    <= ALU_OP_i;
            ready_q <= 1'b0;
            if (is_multi) begin
              p_q     <= {{WIDTH{1'b0}}, a_mag};
              m_q     <= b_mag;
              a_q     <= ALU_RS1_i;
              asgn_q  <= a_sgn;
              bsgn_q  <= b_sgn;
              cnt_q   <= '0;
              state_q <= CALC;
            end else begin
              rd_q    <= sc_res;
              zr_q    <= (sc_res == '0);
              valid_q <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        CALC: begin
          p_q <= p_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            rd_q    <= mc_res;
            zr_q    <= (mc_res == '0);
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DONE: begin
          if (ALU_READY_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ALU_RD_o    = rd_q;
  assign ALU_ZR_o    = zr_q;
  assign ALU_VALID_o = valid_q;
  assign ALU_READY_o = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Brief    : Directed self-checking bench for alu_multicycle (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

  logic        clk;
  logic        rst;
  logic [4:0]  ALU_OP_i;
  logic [31:0] ALU_RS1_i;
  logic [31:0] ALU_RS2_i;
  logic        ALU_VALID_i;
  logic        ALU_READY_o;
  logic [31:0] ALU_RD_o;
  logic        ALU_ZR_o;
  logic        ALU_VALID_o;
  logic        ALU_READY_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  alu_multicycle #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ALU_OP_i    (ALU_OP_i),
    .ALU_RS1_i   (ALU_RS1_i),
    .ALU_RS2_i   (ALU_RS2_i),
    .ALU_VALID_i (ALU_VALID_i),
    .ALU_READY_o (ALU_READY_o),
    .ALU_RD_o    (ALU_RD_o),
    .ALU_ZR_o    (ALU_ZR_o),
    .ALU_VALID_o (ALU_VALID_o),
    .ALU_READY_i (ALU_READY_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the result and score it against the queue.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int          lat;
    int          elat;
    logic [31:0] e;
    exp_q.push_back(exp);
    lat_q.push_back((op[4:3] == 2'b10) ? 33 : 1);
    @(negedge clk);
    check({tag, " ready_o before accept"}, {31'd0, ALU_READY_o}, 32'd1);
    ALU_OP_i    = op;
    ALU_RS1_i   = a;
    ALU_RS2_i   = b;
    ALU_VALID_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ALU_VALID_i = 1'b0;
    ALU_RS1_i   = $urandom;
    ALU_RS2_i   = $urandom;
    ALU_OP_i    = 5'($urandom);
    lat = 1;
    while (!ALU_VALID_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e    = exp_q.pop_front();
    elat = lat_q.pop_front();
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " rd"}, ALU_RD_o, e);
    check({tag, " zr"}, {31'd0, ALU_ZR_o}, {31'd0, (e == 32'd0)});
    ALU_READY_i = 1'b1;
    @(negedge clk);
    ALU_READY_i = 1'b0;
    check({tag, " valid_o after handoff"}, {31'd0, ALU_VALID_o}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    ALU_OP_i    = '0;
    ALU_RS1_i   = '0;
    ALU_RS2_i   = '0;
    ALU_VALID_i = 1'b0;
    ALU_READY_i = 1'b0;
    #1;
    check("reset rd",      ALU_RD_o, 32'd0);
    check("reset zr",      {31'd0, ALU_ZR_o}, 32'd1);
    check("reset valid_o", {31'd0, ALU_VALID_o}, 32'd0);
    check("reset ready_o", {31'd0, ALU_READY_o}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single-cycle ops
    run_op(5'b00010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "ADD wrap");
    run_op(5'b01110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "SLT");
    run_op(5'b01111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "SLTU");
    run_op(5'b00111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "SRA");
    run_op(5'b01010, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, "SUB");
    run_op(5'b00100, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, "SLL");
    run_op(5'b00101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, "SRL");
    run_op(5'b01100, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0000, "GE");
    run_op(5'b01101, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0001, "GEU");
    run_op(5'b00011, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, "EQ");
    run_op(5'b01000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "XOR");
    run_op(5'b01001, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, "NOR");
    run_op(5'b00000, 32'h0000_00F0, 32'h0000_000F, 32'h0000_0000, "AND");
    run_op(5'b00001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, "OR");
    run_op(5'b00110, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, "UNDEF 00110");
    run_op(5'b11111, 32'h1234_5678, 32'h0000_0002, 32'h0000_0000, "UNDEF 11111");

    // Multiply family
    run_op(5'b10000, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFF1, "MUL");
    run_op(5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH");
    run_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU");
    run_op(5'b10010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "MULHSU");
    run_op(5'b10011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "MULHU 2^32");

    // Divide family
    run_op(5'b10100, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, "DIV by 0");
    run_op(5'b10110, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, "REM by 0");
    run_op(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV overflow");
    run_op(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "REM overflow");
    run_op(5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "REM -7/2");
    run_op(5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "DIV -7/2");
    run_op(5'b10100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "DIV 7/-2");
    run_op(5'b10110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, "REM 7/-2");
    run_op(5'b10101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, "DIVU 100/7");
    run_op(5'b10111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, "REMU 100/7");
    run_op(5'b10101, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, "DIVU by 0");
    run_op(5'b10111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "REMU by 0");

    // Back-pressure in DONE: result held, new request ignored
    @(negedge clk);
    ALU_OP_i    = 5'b00010;
    ALU_RS1_i   = 32'd2;
    ALU_RS2_i   = 32'd3;
    ALU_VALID_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ALU_OP_i  = 5'b01010;
    ALU_RS1_i = 32'd9;
    ALU_RS2_i = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("hold valid_o", {31'd0, ALU_VALID_o}, 32'd1);
      check("hold rd",      ALU_RD_o, 32'd5);
      check("hold zr",      {31'd0, ALU_ZR_o}, 32'd0);
      check("hold ready_o", {31'd0, ALU_READY_o}, 32'd0);
      @(negedge clk);
    end
    ALU_READY_i = 1'b1;
    @(posedge clk);
    #1;
    check("release ready_o", {31'd0, ALU_READY_o}, 32'd1);
    check("release valid_o", {31'd0, ALU_VALID_o}, 32'd0);
    @(negedge clk);
    ALU_READY_i = 1'b0;
    ALU_VALID_i = 1'b0;
    @(posedge clk);
    #1;
    check("no accept in DONE", {31'd0, ALU_VALID_o}, 32'd0);
    check("no accept rd",      ALU_RD_o, 32'd5);

    // Reset during CALC aborts, then a fresh divide completes normally
    @(negedge clk);
    ALU_OP_i    = 5'b10101;
    ALU_RS1_i   = 32'd1000;
    ALU_RS2_i   = 32'd3;
    ALU_VALID_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ALU_VALID_i = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort rd",      ALU_RD_o, 32'd0);
    check("abort zr",      {31'd0, ALU_ZR_o}, 32'd1);
    check("abort valid_o", {31'd0, ALU_VALID_o}, 32'd0);
    check("abort ready_o", {31'd0, ALU_READY_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post-abort valid_o", {31'd0, ALU_VALID_o}, 32'd0);
    end
    run_op(5'b10101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, "DIVU after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
